// File: rtl/pwm_pulse_generator.sv
// -----------------------------------------------------------------------------
// pwm_pulse_generator
//
// Turns a duty word (0..2^CNT_W, unit = 1/2^CNT_W of a period) into a
// glitch-free PWM pin drive. The requested duty is saturated and captured into
// a shadow register only at period boundaries, so a period in flight is never
// reshaped. Dropping Enable_In lets the current period finish (DRAIN) before
// the block returns to IDLE.
//
// Optional build macro: PWM_CENTER_ALIGN_EN
//   undefined : edge-aligned, period = 2^CNT_W clocks, counter 0..2^CNT_W-1.
//   defined   : center-aligned, the counter runs 0 up to 2^CNT_W-1 and back
//               down to 0, period = 2^(CNT_W+1) clocks. Pulses are centred on
//               the counter valley, and duty update, DRAIN exit and
//               Period_Start happen at the valley cycle that starts the up
//               slope.
//
// Ports:
//   sysclk        in   system clock, all logic on the rising edge
//   rst           in   synchronous reset, active-high
//   Enable_In     in   run request, level-sensitive
//   Duty_In       in   requested duty; values above 2^CNT_W saturate
//   Pwm_Out       out  registered PWM drive
//   Period_Start  out  one-cycle pulse in the first cycle of a running period
//   Duty_Active   out  duty currently applied (shadow register)
//   Busy          out  high while in RUN or DRAIN
//   o_dbg_state   out  current FSM state (0 = IDLE, 1 = RUN, 2 = DRAIN)
//
// Handshake: none. Enable_In is a level, sampled every rising edge; Duty_In
// is sampled only on the edge that opens a new period.
// -----------------------------------------------------------------------------
module pwm_pulse_generator #(
  parameter int CNT_W  = 6,
  parameter int DUTY_W = 7
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              Enable_In,
  input  logic [DUTY_W-1:0] Duty_In,
  output logic              Pwm_Out,
  output logic              Period_Start,
  output logic [DUTY_W-1:0] Duty_Active,
  output logic              Busy,
  output logic [1:0]        o_dbg_state
);

  localparam int                FULL_I  = 1 << CNT_W;
  localparam logic [DUTY_W-1:0] FULL    = FULL_I[DUTY_W-1:0];
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DUTY_W-1:0]  r_duty;
  logic               r_pwm;
  logic               r_ps;
  logic               r_busy;

  state_t             w_state_n;
  logic [CNT_W-1:0]   w_cnt_n;
  logic [DUTY_W-1:0]  w_duty_n;
  logic [DUTY_W-1:0]  w_sat;
  logic               w_wrap;
  logic               w_run_n;
  logic               w_ps_n;
  logic               w_pwm_n;

`ifdef PWM_CENTER_ALIGN_EN
  // r_down = 1 while the triangle counter is on its down slope.
  logic               r_down;
  logic               w_down_n;
  // The period ends on the valley cycle of the down slope.
  assign w_wrap = r_down && (r_cnt == '0);
`else
  assign w_wrap = (r_cnt == CNT_MAX);
`endif

  assign w_sat = (Duty_In > FULL) ? FULL : Duty_In;

  // Next-state values. Outputs are registered from these so that Pwm_Out and
  // Period_Start line up with the cycle in which cnt/Duty_Active hold them.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_duty_n  = r_duty;
`ifdef PWM_CENTER_ALIGN_EN
    w_down_n  = r_down;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
`ifdef PWM_CENTER_ALIGN_EN
        w_down_n = 1'b0;
`endif
        if (Enable_In) begin
          w_state_n = S_RUN;
          w_duty_n  = w_sat;
        end
      end
      S_RUN, S_DRAIN: begin
        if (w_wrap) begin
          w_cnt_n = '0;
`ifdef PWM_CENTER_ALIGN_EN
          w_down_n = 1'b0;
`endif
          if (Enable_In) begin
            w_state_n = S_RUN;
            w_duty_n  = w_sat;
          end else if (r_state == S_RUN) begin
            // Enable dropped in the last cycle of a RUN period: the new
            // period is the one that drains.
            w_state_n = S_DRAIN;
            w_duty_n  = w_sat;
          end else begin
            w_state_n = S_IDLE;
          end
        end else begin
`ifdef PWM_CENTER_ALIGN_EN
          if (!r_down) begin
            // The peak value is held for two cycles: once on each slope.
            if (r_cnt == CNT_MAX) w_down_n = 1'b1;
            else                  w_cnt_n  = r_cnt + 1'b1;
          end else begin
            w_cnt_n = r_cnt - 1'b1;
          end
`else
          w_cnt_n = r_cnt + 1'b1;
`endif
          w_state_n = Enable_In ? S_RUN : S_DRAIN;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
`ifdef PWM_CENTER_ALIGN_EN
        w_down_n  = 1'b0;
`endif
      end
    endcase
  end

  assign w_run_n = (w_state_n != S_IDLE);
  assign w_pwm_n = w_run_n && (DUTY_W'(w_cnt_n) < w_duty_n);
`ifdef PWM_CENTER_ALIGN_EN
  assign w_ps_n  = w_run_n && (w_cnt_n == '0) && !w_down_n;
`else
  assign w_ps_n  = w_run_n && (w_cnt_n == '0);
`endif

  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_duty  <= '0;
      r_pwm   <= 1'b0;
      r_ps    <= 1'b0;
      r_busy  <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      r_down  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_duty  <= w_duty_n;
      r_pwm   <= w_pwm_n;
      r_ps    <= w_ps_n;
      r_busy  <= w_run_n;
`ifdef PWM_CENTER_ALIGN_EN
      r_down  <= w_down_n;
`endif
    end
  end

  assign Pwm_Out      = r_pwm;
  assign Period_Start = r_ps;
  assign Duty_Active  = r_duty;
  assign Busy         = r_busy;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pwm_pulse_generator.sv
// -----------------------------------------------------------------------------
// tb_pwm_pulse_generator
//
// Directed bench for pwm_pulse_generator. A period-position model predicts
// every output each cycle; directed sequences add hand-computed counts of
// high cycles, period lengths and boundary values.
// -----------------------------------------------------------------------------
module tb_pwm_pulse_generator;

`ifdef PWM_CENTER_ALIGN_EN
  localparam int PER = 128;
`else
  localparam int PER = 64;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic       sysclk = 1'b0;
  logic       rst;
  logic       en;
  logic [6:0] duty;
  logic       pwm;
  logic       ps;
  logic [6:0] duty_act;
  logic       busy;
  logic [1:0] dbg_state;
  int         cyc = 0;

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  pwm_pulse_generator #(.CNT_W(6), .DUTY_W(7)) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .Enable_In   (en),
    .Duty_In     (duty),
    .Pwm_Out     (pwm),
    .Period_Start(ps),
    .Duty_Active (duty_act),
    .Busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- model
  // The model knows only "running or not", the position inside the current
  // period, the applied duty and whether the period is draining.
  int m_run = 0, m_pos = 0, m_duty = 0, m_drain = 0;

  function automatic int sat(input int d);
    return (d > 64) ? 64 : d;
  endfunction

  function automatic int cnt_of(input int p);
`ifdef PWM_CENTER_ALIGN_EN
    return (p < 64) ? p : 127 - p;
`else
    return p;
`endif
  endfunction

  function automatic int hi_of(input int d);
`ifdef PWM_CENTER_ALIGN_EN
    return 2 * d;
`else
    return d;
`endif
  endfunction

  task automatic model_step();
    if (rst) begin
      m_run = 0; m_pos = 0; m_duty = 0; m_drain = 0;
    end else if (m_run == 0) begin
      if (en) begin
        m_run = 1; m_pos = 0; m_duty = sat(int'(duty)); m_drain = 0;
      end
    end else if (m_pos == PER - 1) begin
      if (m_drain != 0 && !en) begin
        m_run = 0; m_pos = 0;
      end else begin
        m_pos = 0; m_duty = sat(int'(duty)); m_drain = en ? 0 : 1;
      end
    end else begin
      m_pos++;
      m_drain = en ? 0 : 1;
    end
  endtask

  // One compare process: model advances on the edge, DUT is sampled 1 later.
  initial begin
    forever begin
      @(posedge sysclk);
      model_step();
      #1;
      check("cyc_pwm",  int'(pwm),      (m_run != 0 && cnt_of(m_pos) < m_duty) ? 1 : 0);
      check("cyc_ps",   int'(ps),       (m_run != 0 && m_pos == 0) ? 1 : 0);
      check("cyc_busy", int'(busy),     m_run);
      check("cyc_duty", int'(duty_act), m_duty);
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic wait_ps(output int c_at);
    c_at = -1;
    for (int k = 0; k < 400; k++) begin
      @(posedge sysclk); #1;
      if (ps) begin
        c_at = cyc;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_ps_timeout: got no Period_Start expected one within 400 cycles");
  endtask

  task automatic count_rest(input int n, inout int hi);
    repeat (n) begin
      @(posedge sysclk); #1;
      hi += int'(pwm);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  int t0, t1, hi;

  initial begin
    rst = 1'b1; en = 1'b0; duty = 7'd0;
    repeat (3) @(negedge sysclk);
    check("rst_pwm",  int'(pwm), 0);
    check("rst_ps",   int'(ps), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_duty", int'(duty_act), 0);
    rst = 1'b0;

    // 50% duty, period length, Busy
    @(negedge sysclk); duty = 7'd32; en = 1'b1;
    wait_ps(t0);
    hi = int'(pwm);
    count_rest(PER - 1, hi);
    check("duty32_high", hi, hi_of(32));
    wait_ps(t1);
    check("period_len", t1 - t0, PER);
    check("busy_run", int'(busy), 1);

    // duty 0, 64 across a wrap, 100 saturates
    @(negedge sysclk); duty = 7'd0;
    wait_ps(t0);
    hi = int'(pwm);
    count_rest(PER - 1, hi);
    check("duty0_high", hi, 0);
    @(negedge sysclk); duty = 7'd64;
    wait_ps(t0);
    check("duty64_act", int'(duty_act), 64);
    hi = int'(pwm);
    count_rest(2 * PER - 1, hi);
    check("duty64_no_glitch", hi, 2 * PER);
    @(negedge sysclk); duty = 7'd100;
    wait_ps(t0);
    check("duty100_sat", int'(duty_act), 64);

    // duty change mid-period: 16 stays for this period, 48 next
    @(negedge sysclk); duty = 7'd16;
    wait_ps(t0);
    hi = int'(pwm);
    count_rest(20, hi);
    @(negedge sysclk); duty = 7'd48;
    count_rest(PER - 21, hi);
    check("mid_change_old", hi, hi_of(16));
    hi = 0;
    count_rest(PER, hi);
    check("mid_change_new", hi, hi_of(48));
    check("mid_change_act", int'(duty_act), 48);

    // drain: enable dropped at position 10
    @(negedge sysclk); duty = 7'd40;
    wait_ps(t0);
    hi = int'(pwm);
    count_rest(10, hi);
    @(negedge sysclk); en = 1'b0;
    count_rest(PER - 11, hi);
    check("drain_high", hi, hi_of(40));
    @(posedge sysclk); #1;
    check("idle_busy", int'(busy), 0);
    check("idle_pwm",  int'(pwm), 0);
    check("idle_ps",   int'(ps), 0);
    hi = 0;
    count_rest(5, hi);
    check("idle_quiet", hi, 0);

    // re-enable inside DRAIN at position 50: period not interrupted
    @(negedge sysclk); en = 1'b1;
    wait_ps(t0);
    hi = int'(pwm);
    count_rest(10, hi);
    @(negedge sysclk); en = 1'b0;
    count_rest(40, hi);
    @(negedge sysclk); en = 1'b1;
    count_rest(PER - 51, hi);
    check("redrain_high", hi, hi_of(40));
    wait_ps(t1);
    check("redrain_len", t1 - t0, PER);
    check("redrain_busy", int'(busy), 1);

    // reset mid-period with Pwm_Out high
    hi = 0;
    count_rest(5, hi);
    check("pre_rst_pwm", int'(pwm), 1);
    @(negedge sysclk); rst = 1'b1;
    @(posedge sysclk); #1;
    check("mid_rst_pwm",  int'(pwm), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ps",   int'(ps), 0);
    check("mid_rst_duty", int'(duty_act), 0);
    @(negedge sysclk); rst = 1'b0; en = 1'b0;
    repeat (4) @(negedge sysclk);
    check("post_rst_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
